// File: rtl/video_memory_if.sv
// Byte-wide Wishbone slave port bundle for the video memory.
interface video_memory_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DATA_BYTES    = 1
);
  logic [ADDRESS_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0]    dat_i;
  logic [DATA_WIDTH-1:0]    dat_o;
  logic                     we_i;
  logic [DATA_BYTES-1:0]    sel_i;
  logic                     stb_i;
  logic                     cyc_i;
  logic                     ack_o;
  logic [2:0]               cti_i;

  modport master (
    output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/video_memory.sv
// Frame buffer RAM with a control block that DMAs frame data from quad-SPI flash (cmd 0x6B).
module video_memory #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DATA_BYTES     = 1,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  video_memory_if.slave wb,
  input  logic          dfu_busy,
  output logic          spi_clk,
  output logic          spi_sel,
  output logic [3:0]    spi_d_out,
  input  logic [3:0]    spi_d_in,
  output logic [3:0]    spi_d_dir
);

  localparam int unsigned MemDepth = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StStart, StShift, StDummy, StData} state_e;

  logic [DATA_WIDTH-1:0] mem [MemDepth];

  // Bus decode
  logic                      req, reg_sel, ram_acc, bus_we, regs_open, start_req, busy;
  logic [DATA_BYTES-1:0]     sel;
  logic [MEM_ADDR_WIDTH-1:0] wb_ram_addr;
  logic [2:0]                reg_addr;
  logic                      unused_in;

  assign sel         = wb.sel_i;
  assign req         = wb.stb_i & wb.cyc_i;
  assign reg_sel     = wb.adr_i[ADDRESS_WIDTH-1];
  assign ram_acc     = req & ~reg_sel;
  assign bus_we      = req & wb.we_i & sel[0];
  assign wb_ram_addr = wb.adr_i[MEM_ADDR_WIDTH-1:0];
  assign reg_addr    = wb.adr_i[2:0];
  assign unused_in   = ^{wb.cti_i, wb.adr_i[ADDRESS_WIDTH-2:MEM_ADDR_WIDTH]};

  // State
  state_e                    state_q, state_d;
  logic                      ack_q, ack_d;
  logic [DATA_WIDTH-1:0]     dat_q, dat_d, rd_reg;
  logic [23:0]               flash_addr_q, flash_addr_d;
  logic [7:0]                dest_page_q, dest_page_d;
  logic [15:0]               len_q, len_d;
  logic                      pending_q, pending_d, error_q, error_d;
  logic                      spi_sel_q, spi_sel_d, spi_clk_q, spi_clk_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [31:0]               shift_q, shift_d;
  logic                      nib_q, nib_d;
  logic [3:0]                hi_q, hi_d;
  logic [15:0]               rem_q, rem_d;
  logic                      dma_pend_q, dma_pend_d;
  logic [DATA_WIDTH-1:0]     dma_data_q, dma_data_d;
  logic [MEM_ADDR_WIDTH-1:0] dma_addr_q, dma_addr_d;

  // RAM port: Wishbone access wins, a pending DMA byte waits for a free cycle
  logic                      dma_we, ram_we;
  logic [MEM_ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]     ram_wdata;

  assign busy      = (state_q != StIdle);
  assign regs_open = ~busy & ~pending_q;
  assign start_req = bus_we & reg_sel & (reg_addr == 3'd0) & wb.dat_i[0] & regs_open;
  assign dma_we    = dma_pend_q & ~ram_acc;
  assign ram_we    = (ram_acc & bus_we) | dma_we;
  assign ram_addr  = ram_acc ? wb_ram_addr : dma_addr_q;
  assign ram_wdata = ram_acc ? wb.dat_i : dma_data_q;

  // RAM write port (contents are not reset)
  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // Bus response and register-file next state
  always_comb begin
    ack_d        = req;
    dat_d        = dat_q;
    flash_addr_d = flash_addr_q;
    dest_page_d  = dest_page_q;
    len_d        = len_q;
    rd_reg       = '0;
    case (reg_addr)
      3'd0: rd_reg = {5'b0, error_q, pending_q, busy};
      3'd1: rd_reg = '0;
      3'd2: rd_reg = flash_addr_q[7:0];
      3'd3: rd_reg = flash_addr_q[15:8];
      3'd4: rd_reg = flash_addr_q[23:16];
      3'd5: rd_reg = dest_page_q;
      3'd6: rd_reg = len_q[7:0];
      3'd7: rd_reg = len_q[15:8];
      default: rd_reg = '0;
    endcase
    if (req & ~wb.we_i) dat_d = reg_sel ? rd_reg : mem[wb_ram_addr];
    if (bus_we & reg_sel & regs_open) begin
      case (reg_addr)
        3'd2: flash_addr_d[7:0]   = wb.dat_i;
        3'd3: flash_addr_d[15:8]  = wb.dat_i;
        3'd4: flash_addr_d[23:16] = wb.dat_i;
        3'd5: dest_page_d         = wb.dat_i;
        3'd6: len_d[7:0]          = wb.dat_i;
        3'd7: len_d[15:8]         = wb.dat_i;
        default: ;
      endcase
    end
  end

  // SPI sequencer and DMA next state
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    error_d    = error_q;
    spi_sel_d  = spi_sel_q;
    spi_clk_d  = spi_clk_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    nib_d      = nib_q;
    hi_d       = hi_q;
    rem_d      = rem_q;
    dma_pend_d = dma_pend_q;
    dma_data_d = dma_data_q;
    dma_addr_d = dma_addr_q;

    if (dma_we) begin
      dma_pend_d = 1'b0;
      dma_addr_d = dma_addr_q + MEM_ADDR_WIDTH'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (pending_q && !dfu_busy) begin
          pending_d = 1'b0;
          state_d   = StStart;
        end
      end
      // One setup cycle keeps chip select high long enough between transfers
      StStart: begin
        spi_sel_d  = 1'b0;
        spi_clk_d  = 1'b0;
        shift_d    = {8'h6B, flash_addr_q};
        cnt_d      = '0;
        rem_d      = len_q;
        dma_addr_d = MEM_ADDR_WIDTH'({dest_page_q, 8'h00});
        state_d    = StShift;
      end
      StShift: begin
        spi_clk_d = ~spi_clk_q;
        if (spi_clk_q) begin
          if (cnt_q == 5'd31) begin
            cnt_d   = '0;
            state_d = StDummy;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            shift_d = {shift_q[30:0], 1'b0};
          end
        end
      end
      StDummy: begin
        spi_clk_d = ~spi_clk_q;
        if (spi_clk_q) begin
          if (cnt_q == 5'd7) begin
            nib_d   = 1'b0;
            state_d = StData;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StData: begin
        spi_clk_d = ~spi_clk_q;
        if (!spi_clk_q) begin
          // Rising flash clock: sample a nibble, high nibble first
          if (!nib_q) begin
            hi_d  = spi_d_in;
            nib_d = 1'b1;
          end else begin
            nib_d      = 1'b0;
            dma_pend_d = 1'b1;
            dma_data_d = {hi_q, spi_d_in};
            rem_d      = rem_q - 16'd1;
          end
        end else if (rem_q == 16'd0) begin
          spi_sel_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (busy && dfu_busy) begin
      state_d   = StIdle;
      spi_sel_d = 1'b1;
      spi_clk_d = 1'b0;
      error_d   = 1'b1;
    end

    if (start_req) begin
      error_d = 1'b0;
      if (len_q != 16'd0) pending_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      flash_addr_q <= '0;
      dest_page_q  <= '0;
      len_q        <= 16'h1000;
      pending_q    <= 1'b0;
      error_q      <= 1'b0;
      spi_sel_q    <= 1'b1;
      spi_clk_q    <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      nib_q        <= 1'b0;
      hi_q         <= '0;
      rem_q        <= '0;
      dma_pend_q   <= 1'b0;
      dma_data_q   <= '0;
      dma_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      flash_addr_q <= flash_addr_d;
      dest_page_q  <= dest_page_d;
      len_q        <= len_d;
      pending_q    <= pending_d;
      error_q      <= error_d;
      spi_sel_q    <= spi_sel_d;
      spi_clk_q    <= spi_clk_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      nib_q        <= nib_d;
      hi_q         <= hi_d;
      rem_q        <= rem_d;
      dma_pend_q   <= dma_pend_d;
      dma_data_q   <= dma_data_d;
      dma_addr_q   <= dma_addr_d;
    end
  end

  // Lane drive only during command/address; otherwise idle values
  always_comb begin
    spi_d_out = 4'b1100;
    spi_d_dir = 4'b0000;
    if (state_q == StShift) begin
      spi_d_dir = 4'b1101;
      spi_d_out = {3'b110, shift_q[31]};
    end
  end

  assign wb.ack_o = ack_q;
  assign wb.dat_o = dat_q;
  assign spi_sel  = spi_sel_q;
  assign spi_clk  = spi_clk_q;

endmodule

// File: tb/tb_video_memory.sv
// Directed self-checking bench for video_memory with a behavioural quad-SPI flash.
module tb_video_memory;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       dfu_busy = 1'b0;
  logic       spi_clk, spi_sel;
  logic [3:0] spi_d_out, spi_d_dir;
  logic [3:0] spi_d_in = 4'h0;

  int errors = 0;
  int checks = 0;

  video_memory_if wb_if ();

  video_memory dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wb        (wb_if),
    .dfu_busy  (dfu_busy),
    .spi_clk   (spi_clk),
    .spi_sel   (spi_sel),
    .spi_d_out (spi_d_out),
    .spi_d_in  (spi_d_in),
    .spi_d_dir (spi_d_dir)
  );

  always #5 clk_i = ~clk_i;

  // Flash contents: fixed first four bytes, then a simple pattern
  function automatic logic [7:0] fbyte(input int i);
    case (i)
      0: return 8'hDE;
      1: return 8'hAD;
      2: return 8'hBE;
      3: return 8'hEF;
      default: return 8'(i) ^ 8'h5A;
    endcase
  endfunction

  int          clk_cnt = 0;
  int          last_cnt = 0;
  logic [31:0] cmd_shift = '0;

  always @(posedge spi_clk or posedge spi_sel) begin
    if (spi_sel) begin
      if (clk_cnt != 0) last_cnt <= clk_cnt;
      clk_cnt <= 0;
    end else begin
      if (clk_cnt < 32) cmd_shift <= {cmd_shift[30:0], spi_d_out[0]};
      clk_cnt <= clk_cnt + 1;
    end
  end

  always @(negedge spi_clk) begin
    if (spi_sel === 1'b0 && clk_cnt >= 40) begin
      int n;
      logic [7:0] b;
      n = clk_cnt - 40;
      b = fbyte(n / 2);
      spi_d_in = n[0] ? b[3:0] : b[7:4];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
    @(negedge clk_i);
    wb_if.adr_i = a;
    wb_if.we_i  = w;
    wb_if.dat_i = d;
    wb_if.sel_i = 1'b1;
    wb_if.stb_i = 1'b1;
    wb_if.cyc_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("ack", wb_if.ack_o, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk_i);
    wb_if.stb_i = 1'b0;
    wb_if.cyc_i = 1'b0;
    wb_if.we_i  = 1'b0;
    @(posedge clk_i);
    #1;
    check("ack_low", wb_if.ack_o, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
    bus(a, 1'b0, 8'h00);
    check(tag, wb_if.dat_o, exp);
  endtask

  task automatic wait_sel(input logic lvl, input int max, input string tag);
    int n = 0;
    while (spi_sel !== lvl && n < max) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check(tag, spi_sel, lvl);
  endtask

  initial begin
    wb_if.adr_i = '0;
    wb_if.dat_i = '0;
    wb_if.we_i  = 1'b0;
    wb_if.sel_i = 1'b0;
    wb_if.stb_i = 1'b0;
    wb_if.cyc_i = 1'b0;
    wb_if.cti_i = 3'b000;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", wb_if.ack_o, 1'b0);
    check("rst_dat", wb_if.dat_o, 8'h00);
    check("rst_sel", spi_sel, 1'b1);
    check("rst_clk", spi_clk, 1'b0);
    check("rst_dout", spi_d_out, 4'b1100);
    check("rst_dir", spi_d_dir, 4'b0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    rd(16'h8000, 8'h00, "rst_ctrl");
    rd(16'h8006, 8'h00, "rst_len_lo");
    rd(16'h8007, 8'h10, "rst_len_hi");
    rd(16'h8004, 8'h00, "rst_faddr_hi");
    rd(16'h8005, 8'h00, "rst_page");
    idle();

    // RAM write/read and mirror
    bus(16'h0010, 1'b1, 8'hA5);
    idle();
    rd(16'h0010, 8'hA5, "ram_rd");
    idle();
    rd(16'h1010, 8'hA5, "ram_mirror");
    idle();

    // Back-to-back register writes
    bus(16'h8002, 1'b1, 8'h11);
    bus(16'h8003, 1'b1, 8'h22);
    bus(16'h8004, 1'b1, 8'h01);
    bus(16'h8005, 1'b1, 8'h00);
    bus(16'h8006, 1'b1, 8'h04);
    bus(16'h8007, 1'b1, 8'h00);
    rd(16'h8002, 8'h11, "reg2");
    rd(16'h8003, 8'h22, "reg3");
    rd(16'h8004, 8'h01, "reg4");
    rd(16'h8005, 8'h00, "reg5");
    rd(16'h8006, 8'h04, "reg6");
    rd(16'h8007, 8'h00, "reg7");
    rd(16'h8001, 8'h00, "reg1");
    idle();

    // Four-byte DMA
    bus(16'h8000, 1'b1, 8'h01);
    idle();
    wait_sel(1'b0, 10, "dma_sel_low");
    check("cmd_dir", spi_d_dir, 4'b1101);
    check("cmd_dout_hi", spi_d_out[3:2], 2'b11);
    wait_sel(1'b1, 400, "dma_sel_high");
    check("cmd_addr", cmd_shift, 32'h6B01_2211);
    check("dma_clks", last_cnt, 48);
    check("end_clk", spi_clk, 1'b0);
    check("end_dir", spi_d_dir, 4'b0000);
    idle();
    rd(16'h0000, 8'hDE, "dma_b0");
    rd(16'h0001, 8'hAD, "dma_b1");
    rd(16'h0002, 8'hBE, "dma_b2");
    rd(16'h0003, 8'hEF, "dma_b3");
    rd(16'h8000, 8'h00, "dma_ctrl_end");
    idle();

    // Start held off by DFU, then aborted by DFU
    dfu_busy = 1'b1;
    bus(16'h8000, 1'b1, 8'h01);
    idle();
    rd(16'h8000, 8'h02, "pend_ctrl");
    idle();
    repeat (5) @(posedge clk_i);
    #1;
    check("pend_sel", spi_sel, 1'b1);
    @(negedge clk_i);
    dfu_busy = 1'b0;
    wait_sel(1'b0, 10, "pend_go");
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    dfu_busy = 1'b1;
    @(posedge clk_i);
    #1;
    check("abort_sel", spi_sel, 1'b1);
    check("abort_dir", spi_d_dir, 4'b0000);
    rd(16'h8000, 8'h04, "abort_ctrl");
    idle();
    @(negedge clk_i);
    dfu_busy = 1'b0;

    // Wrapping 512-byte DMA from page 0x0F, with bus reads interleaved
    bus(16'h0100, 1'b1, 8'h33);
    bus(16'h8005, 1'b1, 8'h0F);
    bus(16'h8006, 1'b1, 8'h00);
    bus(16'h8007, 1'b1, 8'h02);
    bus(16'h8000, 1'b1, 8'h01);
    idle();
    wait_sel(1'b0, 10, "wrap_sel_low");
    repeat (100) @(posedge clk_i);
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 3; k++) rd(16'h0100, 8'h33, "wrap_coll_rd");
      idle();
    end
    wait_sel(1'b1, 3000, "wrap_sel_high");
    check("wrap_clks", last_cnt, 1064);
    idle();
    rd(16'h0F00, 8'hDE, "wrap_first");
    rd(16'h0FFF, 8'hA5, "wrap_fff");
    rd(16'h0000, 8'h5A, "wrap_000");
    rd(16'h00FF, 8'hA5, "wrap_last");
    rd(16'h0100, 8'h33, "wrap_beyond");
    rd(16'h8000, 8'h00, "wrap_ctrl");
    idle();

    // Zero length start does nothing
    bus(16'h8007, 1'b1, 8'h00);
    bus(16'h8000, 1'b1, 8'h01);
    rd(16'h8000, 8'h00, "len0_ctrl");
    idle();
    repeat (4) @(posedge clk_i);
    #1;
    check("len0_sel", spi_sel, 1'b1);

    // Reset mid-transfer
    bus(16'h8006, 1'b1, 8'h04);
    bus(16'h8000, 1'b1, 8'h01);
    idle();
    wait_sel(1'b0, 10, "rst_xfer_low");
    repeat (10) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("rst_mid_sel", spi_sel, 1'b1);
    check("rst_mid_clk", spi_clk, 1'b0);
    check("rst_mid_dir", spi_d_dir, 4'b0000);
    check("rst_mid_dout", spi_d_out, 4'b1100);
    @(negedge clk_i);
    rst_i = 1'b0;
    rd(16'h8007, 8'h10, "rst_mid_len_hi");
    rd(16'h8006, 8'h00, "rst_mid_len_lo");
    rd(16'h8002, 8'h00, "rst_mid_faddr");
    rd(16'h8000, 8'h00, "rst_mid_ctrl");
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
